reversing_bits_arbiter: RTL
===========================

// Module: reversing_bits_arbiter
// PURPOSE
// - Shares one reversing_bits datapath between NUM_REQ requesters.
// - Uses a round-robin arbiter and a valid/ready handshake on every port.
// - Registers the reversed word, tagged with the winning requester ID, in a single-entry output slot.
// - Sits between the bit-manipulation clients and the downstream consumer.
//   Is the only block that drives the reverser's din.
// PARAMETERS
// - DATA_WIDTH  32  width of each data word; passed through to reversing_bits
// - NUM_REQ     4   number of requesters, >=2
// - ID_W        $clog2(NUM_REQ)  localparam, width of out_id
// PORTS
// - clk        in   1                   single clock; all logic on posedge
// - reset      in   1                   synchronous, active-high
// - req_valid  in   NUM_REQ             per-requester data valid
// - req_data   in   NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
// - req_ready  out  NUM_REQ             one-hot or zero; grant/accept to requester i
// - out_valid  out  1                   output slot holds a result
// - out_ready  in   1                   consumer accepts the result
// - out_data   out  DATA_WIDTH          reversed word: out_data[k] = din[DATA_WIDTH-1-k]
// - out_id     out  ID_W                index of the requester that produced out_data
// BEHAVIOUR
// - Reset (sampled on posedge clk while reset=1):
//   - Outputs: out_valid=0, out_data=0, out_id=0.
//   - Round-robin pointer rr_ptr=0, so requester 0 has highest priority.
//   - FSM=EMPTY.
// - FSM states:
//   - EMPTY: slot free.
//   - FULL: slot holds a result.
// - slot_free = (state==EMPTY) | (out_valid & out_ready).
//   A drain and a load in the same cycle are legal; the FSM stays FULL.
// - Arbitration (combinational):
//   - Scan requesters starting at rr_ptr and moving upward, wrapping modulo NUM_REQ.
//   - The first i with req_valid[i]=1 wins.
//   - req_ready[i] = slot_free & win[i]. At most one bit is set.
// - Transfer: requester i transfers when req_valid[i] & req_ready[i] at a posedge. On that edge:
//   - out_data <= reverse(req_data[i])
//   - out_id <= i
//   - out_valid <= 1
//   - rr_ptr <= (i+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0)
// - Latency: 1 cycle from the accepting edge to out_valid=1.
//   Throughput is 1 word/cycle when out_ready is held at 1.
// - Transitions:
//   - EMPTY -> FULL on a transfer.
//   - FULL -> EMPTY on a drain with no transfer.
//   - FULL -> FULL on a drain plus a transfer, or on a stall.
// - Stall (out_valid=1, out_ready=0):
//   - out_data and out_id stay stable.
//   - req_ready=0.
//   - rr_ptr holds.
// - rr_ptr changes only on a transfer. With no req_valid asserted, rr_ptr holds.
// - Fairness: a requester holding req_valid=1 is granted within NUM_REQ transfers.
// - Requester i must hold req_data stable while req_valid[i]=1 and req_ready[i]=0.
//   The arbiter does not latch un-granted data.
// - Reset mid-operation: an occupied slot is discarded (out_valid=0 on the next cycle).
//   An in-flight grant in the reset cycle is not accepted.
// - No X-propagation: out_data holds its last value when out_valid=0.
// STRUCTURE
// - Package reverse_pkg:
//   - DATA_WIDTH default
//   - typedef enum logic {EMPTY, FULL} rb_state_t
//   - function rr_next(ptr, idx) for pointer wrap
// - Sub-module: a single reversing_bits instance (din = muxed granted word, dout -> slot D-input).
//   Arbiter, mux and slot are inline in this module.
// TESTING
// 1. Reset then single transfer. Assert reset for 2 cycles, then req_valid[0]=1, req_data0=32'h0000000B.
//    -> out_valid=1 one cycle after acceptance; out_data=32'hD0000000, out_id=0.
// 2. All requesters valid, out_ready=1. Data: r0=32'h00000001, r1=32'h12345678, r2=32'hFFFF0000, r3=32'h0.
//    -> Grants in order 0,1,2,3,0.
//    -> out_data sequence 80000000, 1E6A2C48, 0000FFFF, 00000000.
// 3. Backpressure: hold out_ready=0 for 5 cycles with r2 valid.
//    -> req_ready=0 throughout; out_data and out_id frozen.
//    -> When out_ready rises, drain and load in the same cycle; out_valid stays 1.
// 4. Wrap-around: last grant 3, then only r1 and r3 valid.
//    -> Next grant is 1 (rr_ptr wrapped to 0, scan 0->1).
//    -> r3 is granted on the following transfer.
// 5. Reset mid-operation: slot FULL (out_data=32'h1E6A2C48), assert reset with r1 valid.
//    -> Next cycle out_valid=0, req_ready not honoured, rr_ptr=0.
//    -> After release, r0 is preferred over r1.
// 6. Random: 1000 cycles of random valids, data and out_ready.
//    - Scoreboard: every output equals the bit-reversal of its source word.
//    - out_id is correct; no drops or duplicates.
//    - Per-requester wait is at most NUM_REQ transfers.

Source files
------------

// File: rtl/reverse_pkg.sv
// reverse_pkg: shared defaults, slot state type and round-robin index helper
package reverse_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic {EMPTY, FULL} rb_state_t;
  function automatic int rr_next(input int ptr, input int idx, input int n);
    return (ptr + idx) % n;
  endfunction
endpackage

// File: rtl/reversing_bits.sv
// reversing_bits: combinational bit-order reversal of one word
module reversing_bits
  import reverse_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign dout[i] = din[DATA_WIDTH-1-i];
  end
endmodule

// File: rtl/reversing_bits_arbiter.sv
// reversing_bits_arbiter: round-robin sharing of one bit reverser with a single-entry tagged output slot
module reversing_bits_arbiter
  import reverse_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id
);
  rb_state_t state;
  logic [ID_W-1:0] rr_ptr, gnt_id, idx;
  logic found, slot_free, xfer;
  logic [DATA_WIDTH-1:0] din, dout;
  // scan upward from rr_ptr with wrap; the first valid requester wins
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'(rr_next(int'(rr_ptr), k, NUM_REQ));
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign slot_free = (state == EMPTY) || (out_valid && out_ready);
  assign xfer = slot_free && found;
  assign req_ready = xfer ? NUM_REQ'(1) << gnt_id : '0;
  assign din = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  reversing_bits #(.DATA_WIDTH(DATA_WIDTH)) u_rev (
    .din (din),
    .dout(dout)
  );
  // slot FSM: load on transfer (also while draining), empty on a bare drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      state <= FULL;
      out_valid <= 1'b1;
      out_data <= dout;
      out_id <= gnt_id;
      rr_ptr <= ID_W'(rr_next(int'(gnt_id), 1, NUM_REQ));
    end else if (out_valid && out_ready) begin
      state <= EMPTY;
      out_valid <= 1'b0;
    end
  end
endmodule
